// File: rtl/phv_fifo_param.sv
// PHV buffer between the last match-action stage and the deparser.
// Single storage array, first-word-fall-through head register, programmable
// nearly-full threshold, occupancy output and saturating overflow-drop counter.
module phv_fifo_param #(
  parameter int PHV_WIDTH    = 1124,
  parameter int DEPTH_LOG2   = 5,
  parameter int AFULL_THRESH = 24
) (
  input  logic                  clk,
  input  logic                  aresetn,
  input  logic [PHV_WIDTH-1:0]  phv_in,
  input  logic                  phv_in_valid,
  output logic [PHV_WIDTH-1:0]  phv_out,
  output logic                  phv_out_valid,
  input  logic                  phv_rd_en,
  output logic                  empty,
  output logic                  full,
  output logic                  nearly_full,
  output logic [DEPTH_LOG2:0]   count,
  output logic [31:0]           drop_cnt,
  input  logic                  clear_drop
);

  localparam int CW = DEPTH_LOG2 + 1;
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL_C = CW'(AFULL_THRESH);
  localparam logic [CW-1:0] ONE_C   = CW'(1);

  logic [PHV_WIDTH-1:0]  mem [DEPTH];
  logic [PHV_WIDTH-1:0]  phv_out_q;
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic [CW-1:0]         remain;
  logic                  empty_q, empty_d;
  logic                  full_q, full_d;
  logic                  nearly_full_q, nearly_full_d;
  logic                  valid_q, valid_d;
  logic [31:0]           drop_cnt_q, drop_cnt_d;
  logic                  accept, pop, drop;
  logic                  head_bypass, head_load;

  // Next-state: handshake decode, pointers, occupancy, flags and drop counter.
  always_comb begin
    pop    = phv_rd_en & ~empty_q;
    accept = phv_in_valid & (~full_q | pop);
    drop   = phv_in_valid & full_q & ~pop;

    wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(accept);
    rd_ptr_d = rd_ptr_q + DEPTH_LOG2'(pop);
    count_d  = count_q + CW'(accept) - CW'(pop);

    // Entries left of the old contents once this cycle's pop is applied.
    // If none remain, an accepted write becomes the head directly, since
    // the array cannot return it until the following cycle.
    remain      = count_q - CW'(pop);
    head_bypass = accept & (remain == '0);
    head_load   = pop & (count_q > ONE_C);

    empty_d       = (count_d == '0);
    valid_d       = (count_d != '0);
    full_d        = (count_d == DEPTH_C);
    nearly_full_d = (count_d >= AFULL_C);

    drop_cnt_d = drop_cnt_q;
    if (clear_drop) begin
      drop_cnt_d = '0;
    end else if (drop && (drop_cnt_q != 32'hFFFF_FFFF)) begin
      drop_cnt_d = drop_cnt_q + 32'd1;
    end
  end

  // Control state registers; reset discards queued entries.
  always_ff @(posedge clk) begin
    if (!aresetn) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      empty_q       <= 1'b1;
      valid_q       <= 1'b0;
      full_q        <= 1'b0;
      nearly_full_q <= 1'b0;
      drop_cnt_q    <= '0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      empty_q       <= empty_d;
      valid_q       <= valid_d;
      full_q        <= full_d;
      nearly_full_q <= nearly_full_d;
      drop_cnt_q    <= drop_cnt_d;
    end
  end

  // Storage write port; contents are deliberately left intact across reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      mem[wr_ptr_q] <= phv_in;
    end
  end

  // Head register: registered array read at the post-pop pointer, with a
  // bypass for a write landing in an otherwise empty queue. It holds its
  // value when the queue drains.
  always_ff @(posedge clk) begin
    if (!aresetn) begin
      phv_out_q <= '0;
    end else if (head_bypass) begin
      phv_out_q <= phv_in;
    end else if (head_load) begin
      phv_out_q <= mem[rd_ptr_d];
    end
  end

  assign phv_out       = phv_out_q;
  assign phv_out_valid = valid_q;
  assign empty         = empty_q;
  assign full          = full_q;
  assign nearly_full   = nearly_full_q;
  assign count         = count_q;
  assign drop_cnt      = drop_cnt_q;

endmodule
